// File: rtl/row4_feeder.sv
// row4_feeder: loads four FP16 weights, then streams x_len X samples into a 4-wide MAC row and drains.
// Define ROW4_FEEDER_WSKIP_EN to add reload_w, which lets a job reuse weights already loaded.
module row4_feeder #(
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 12
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ROW4_FEEDER_WSKIP_EN
  input  logic             reload_w,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] x_len,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [15:0]      w_data,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [15:0]      x_data,
  output logic [15:0]      W_o,
  output logic [3:0]       enW,
  output logic [15:0]      X_o,
  output logic             enX,
  output logic             busy,
  output logic             done
);
  localparam int DW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  state_t           state;
  logic [1:0]       w_idx;
  logic [LEN_W-1:0] len_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             skip_w;
`ifdef ROW4_FEEDER_WSKIP_EN
  logic             w_loaded;
  assign skip_w = !reload_w && w_loaded;
`else
  assign skip_w = 1'b0;
`endif
  assign busy    = state != IDLE;
  assign w_ready = state == LOAD_W;
  assign x_ready = state == STREAM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_idx     <= '0;
      len_cnt   <= '0;
      drain_cnt <= '0;
      W_o       <= '0;
      enW       <= '0;
      X_o       <= '0;
      enX       <= 1'b0;
      done      <= 1'b0;
`ifdef ROW4_FEEDER_WSKIP_EN
      w_loaded  <= 1'b0;
`endif
    end else begin
      enW  <= '0;
      enX  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len_cnt   <= x_len;
          w_idx     <= '0;
          drain_cnt <= DW'(DRAIN_CYCLES);
          state     <= skip_w ? (x_len != '0 ? STREAM : DRAIN) : LOAD_W;
        end
        LOAD_W: if (w_valid) begin
          W_o   <= w_data;
          enW   <= 4'b0001 << w_idx;
          w_idx <= w_idx + 2'd1;
          if (w_idx == 2'd3) begin
            state     <= len_cnt != '0 ? STREAM : DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
`ifdef ROW4_FEEDER_WSKIP_EN
            w_loaded  <= 1'b1;
`endif
          end
        end
        STREAM: if (x_valid) begin
          X_o     <= x_data;
          enX     <= 1'b1;
          len_cnt <= len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: if (drain_cnt == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else drain_cnt <= drain_cnt - DW'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_row4_feeder.sv
// tb_row4_feeder: directed vector table, corner sequences and randomized jobs against a job-level model.
module tb_row4_feeder;
  localparam int D  = 4;
  localparam int LW = 8;
`ifdef ROW4_FEEDER_WSKIP_EN
  localparam bit WSKIP = 1'b1;
`else
  localparam bit WSKIP = 1'b0;
`endif
  logic clk = 0, rst_n = 1, start = 0, w_valid = 0, x_valid = 0, reload_w = 1;
  logic [LW-1:0] x_len = 0;
  logic [15:0] w_data = 0, x_data = 0;
  logic w_ready, x_ready, enX, busy, done;
  logic [15:0] W_o, X_o;
  logic [3:0] enW;
  int total = 0, bad = 0;
  int enx_cnt = 0, enw_cnt = 0, done_cnt = 0;
  // job-level model: beats still owed per phase plus a countdown to done
  logic m_busy, m_loaded, m_enx, m_done;
  logic [3:0] m_enw;
  logic [15:0] m_wo, m_xo;
  int m_wleft, m_xleft, m_dleft;

  row4_feeder #(.LEN_W(LW), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROW4_FEEDER_WSKIP_EN
    .reload_w(reload_w),
`endif
    .start(start), .x_len(x_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .W_o(W_o), .enW(enW), .X_o(X_o), .enX(enX), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic check_all();
    chk("W_o", W_o, m_wo);
    chk("enW", enW, m_enw);
    chk("X_o", X_o, m_xo);
    chk("enX", enX, m_enx);
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("w_ready", w_ready, m_busy && m_wleft > 0);
    chk("x_ready", x_ready, m_busy && m_wleft == 0 && m_xleft > 0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_loaded = 0; m_enx = 0; m_done = 0; m_enw = 0;
    m_wo = 0; m_xo = 0; m_wleft = 0; m_xleft = 0; m_dleft = 0;
  endtask

  task automatic cyc(input logic st, input logic [LW-1:0] xl, input logic wv, input logic [15:0] wd,
                     input logic xv, input logic [15:0] xd);
    start = st; x_len = xl; w_valid = wv; w_data = wd; x_valid = xv; x_data = xd;
    m_enw = 0; m_enx = 0; m_done = 0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1;
        m_xleft = int'(xl);
        m_wleft = (WSKIP && !reload_w && m_loaded) ? 0 : 4;
        if (m_wleft == 0 && m_xleft == 0) m_dleft = D + 1;
      end
    end else if (m_wleft > 0) begin
      if (wv) begin
        m_enw = 4'b0001 << (4 - m_wleft);
        m_wo = wd;
        m_wleft--;
        if (m_wleft == 0) begin
          m_loaded = 1;
          if (m_xleft == 0) m_dleft = D + 1;
        end
      end
    end else if (m_xleft > 0) begin
      if (xv) begin
        m_enx = 1;
        m_xo = xd;
        m_xleft--;
        if (m_xleft == 0) m_dleft = D + 1;
      end
    end else begin
      m_dleft--;
      if (m_dleft == 0) begin
        m_done = 1;
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    if (enX) enx_cnt++;
    if (enW != 0) enw_cnt++;
    if (done) done_cnt++;
    check_all();
  endtask

  task automatic run_job(input int pct);
    for (int k = 0; k < 3000 && m_busy; k++)
      cyc($urandom % 4 == 0, LW'($urandom), ($urandom % 100) < pct, 16'($urandom),
          ($urandom % 100) < pct, 16'($urandom));
    chk("job_finished", busy, 0);
  endtask

  task automatic hard_reset();
    start = 0; w_valid = 0; x_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 check_all();
  endtask

  typedef struct {
    logic st; logic [LW-1:0] xl; logic wv; logic [15:0] wd; logic xv; logic [15:0] xd;
    logic [3:0] enw; logic [15:0] wo; logic enx; logic [15:0] xo; logic dn, bz, wr, xr;
  } vec_t;
  vec_t v[17];

  initial begin
    v[0]  = '{1, 3, 0, 16'h0000, 0, 16'h0000, 4'h0, 16'h0000, 0, 16'h0000, 0, 1, 1, 0};
    v[1]  = '{0, 9, 1, 16'h3C00, 1, 16'h1111, 4'h1, 16'h3C00, 0, 16'h0000, 0, 1, 1, 0};
    v[2]  = '{0, 0, 1, 16'h4000, 0, 16'h0000, 4'h2, 16'h4000, 0, 16'h0000, 0, 1, 1, 0};
    v[3]  = '{0, 0, 1, 16'h4200, 0, 16'h0000, 4'h4, 16'h4200, 0, 16'h0000, 0, 1, 1, 0};
    v[4]  = '{0, 0, 1, 16'h4400, 0, 16'h0000, 4'h8, 16'h4400, 0, 16'h0000, 0, 1, 0, 1};
    v[5]  = '{0, 0, 0, 16'h0000, 0, 16'h0000, 4'h0, 16'h4400, 0, 16'h0000, 0, 1, 0, 1};
    v[6]  = '{0, 0, 0, 16'h0000, 1, 16'h3C00, 4'h0, 16'h4400, 1, 16'h3C00, 0, 1, 0, 1};
    v[7]  = '{0, 0, 1, 16'h5555, 0, 16'h0000, 4'h0, 16'h4400, 0, 16'h3C00, 0, 1, 0, 1};
    v[8]  = '{0, 0, 0, 16'h0000, 1, 16'h3800, 4'h0, 16'h4400, 1, 16'h3800, 0, 1, 0, 1};
    v[9]  = '{1, 7, 0, 16'h0000, 0, 16'h0000, 4'h0, 16'h4400, 0, 16'h3800, 0, 1, 0, 1};
    v[10] = '{0, 0, 0, 16'h0000, 1, 16'hBC00, 4'h0, 16'h4400, 1, 16'hBC00, 0, 1, 0, 0};
    for (int i = 11; i < 15; i++)
      v[i] = '{0, 0, 1, 16'h1234, 1, 16'h4321, 4'h0, 16'h4400, 0, 16'hBC00, 0, 1, 0, 0};
    v[15] = '{0, 0, 0, 16'h0000, 0, 16'h0000, 4'h0, 16'h4400, 0, 16'hBC00, 1, 0, 0, 0};
    v[16] = '{0, 0, 0, 16'h0000, 0, 16'h0000, 4'h0, 16'h4400, 0, 16'hBC00, 0, 0, 0, 0};

    model_reset();
    #1 rst_n = 0;
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 check_all();

    for (int i = 0; i < 17; i++) begin
      cyc(v[i].st, v[i].xl, v[i].wv, v[i].wd, v[i].xv, v[i].xd);
      chk($sformatf("v%0d_enW", i), enW, v[i].enw);
      chk($sformatf("v%0d_W_o", i), W_o, v[i].wo);
      chk($sformatf("v%0d_enX", i), enX, v[i].enx);
      chk($sformatf("v%0d_X_o", i), X_o, v[i].xo);
      chk($sformatf("v%0d_done", i), done, v[i].dn);
      chk($sformatf("v%0d_busy", i), busy, v[i].bz);
      chk($sformatf("v%0d_w_ready", i), w_ready, v[i].wr);
      chk($sformatf("v%0d_x_ready", i), x_ready, v[i].xr);
    end

    // zero-length job: weights only, then drain
    reload_w = 1; enx_cnt = 0; enw_cnt = 0; done_cnt = 0;
    cyc(1, 0, 0, 0, 0, 0);
    run_job(70);
    chk("zero_len_enW", enw_cnt, 4);
    chk("zero_len_enX", enx_cnt, 0);
    chk("zero_len_done", done_cnt, 1);

    // reset after 2 of 5 X beats
    done_cnt = 0;
    cyc(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'(16'h4000 + i), 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 16'(16'h3000 + i));
    hard_reset();
    chk("reset_no_done", done_cnt, 0);
    enx_cnt = 0;
    cyc(1, 2, 0, 0, 0, 0);
    run_job(100);
    chk("after_reset_enX", enx_cnt, 2);
    chk("after_reset_done", done_cnt, 1);

`ifdef ROW4_FEEDER_WSKIP_EN
    reload_w = 0;
    cyc(1, 2, 1, 16'hAAAA, 0, 0);
    chk("skip_x_ready", x_ready, 1);
    chk("skip_w_ready", w_ready, 0);
    run_job(60);
    reload_w = 1;
`endif

    // maximum length job
    enx_cnt = 0; done_cnt = 0;
    cyc(1, LW'(255), 0, 0, 0, 0);
    run_job(100);
    chk("max_len_enX", enx_cnt, 255);
    chk("max_len_done", done_cnt, 1);

    for (int j = 0; j < 40; j++) begin
      reload_w = 1'($urandom);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        cyc(0, LW'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      cyc(1, LW'($urandom_range(0, 6)), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      if (j % 9 == 4) begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++)
          cyc(0, LW'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
        hard_reset();
      end else run_job(int'($urandom_range(30, 100)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
